// File: rtl/adder_share_arb_if.sv
// Requester-side bus of adder_share_arb: per-requester request handshake plus one-hot response.
// rsp_cout exists only when ADD_ARB_COUT_EN is defined.
interface adder_share_arb_if #(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 4
);
  // Handshake: requester i transfers an operation in any cycle where
  // req_valid[i] && req_ready[i]; it holds valid and operands stable until then.
  // Responses carry no backpressure and must be taken in the cycle rsp_valid shows them.
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_op0;
  logic [NUM_REQ*WIDTH-1:0] req_op1;
  logic [NUM_REQ-1:0]       rsp_valid;
  logic [WIDTH-1:0]         rsp_data;
`ifdef ADD_ARB_COUT_EN
  logic                     rsp_cout;
`endif

  modport master (
    output req_valid, req_op0, req_op1,
`ifdef ADD_ARB_COUT_EN
    input  rsp_cout,
`endif
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_op0, req_op1,
`ifdef ADD_ARB_COUT_EN
    output rsp_cout,
`endif
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/adder_share_arb.sv
// Round-robin share of one fixed-latency pipelined adder among NUM_REQ requesters.
// Optional macro ADD_ARB_COUT_EN adds the unsigned carry-out on the response.
module adder_share_arb #(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 4,
  parameter int LAT     = 3
) (
  input  logic             clk,
  input  logic             rst,
  adder_share_arb_if.slave bus,
  output logic [WIDTH-1:0] add_op0,
  output logic [WIDTH-1:0] add_op1,
  input  logic [WIDTH-1:0] add_out
);
  localparam int IDW = $clog2(NUM_REQ);

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] grant_id;
  logic           grant;
  int             idx;

  logic [LAT-1:0] tag_vld;
  logic [IDW-1:0] tag_id [LAT];
`ifdef ADD_ARB_COUT_EN
  logic [LAT-1:0] tag_a;
  logic [LAT-1:0] tag_b;
`endif

  // Scan from ptr, wrapping; the first requester found wins.
  always_comb begin
    grant    = 1'b0;
    grant_id = '0;
    idx      = 0;
    if (!rst) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = int'(ptr) + k;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        if (!grant && bus.req_valid[idx]) begin
          grant    = 1'b1;
          grant_id = IDW'(idx);
        end
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    add_op0       = '0;
    add_op1       = '0;
    if (grant) begin
      bus.req_ready[grant_id] = 1'b1;
      add_op0 = bus.req_op0[int'(grant_id)*WIDTH +: WIDTH];
      add_op1 = bus.req_op1[int'(grant_id)*WIDTH +: WIDTH];
    end
  end

  // Tag pipe runs in lockstep with the adder; reset drops in-flight tags so their sums are never routed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr     <= '0;
      tag_vld <= '0;
      for (int s = 0; s < LAT; s++) tag_id[s] <= '0;
`ifdef ADD_ARB_COUT_EN
      tag_a   <= '0;
      tag_b   <= '0;
`endif
    end else begin
      if (grant) ptr <= IDW'((int'(grant_id) + 1) % NUM_REQ);
      for (int s = LAT-1; s > 0; s--) begin
        tag_vld[s] <= tag_vld[s-1];
        tag_id[s]  <= tag_id[s-1];
`ifdef ADD_ARB_COUT_EN
        tag_a[s]   <= tag_a[s-1];
        tag_b[s]   <= tag_b[s-1];
`endif
      end
      tag_vld[0] <= grant;
      tag_id[0]  <= grant_id;
`ifdef ADD_ARB_COUT_EN
      tag_a[0]   <= add_op0[WIDTH-1];
      tag_b[0]   <= add_op1[WIDTH-1];
`endif
    end
  end

  always_comb begin
    bus.rsp_valid = '0;
    bus.rsp_data  = '0;
    if (tag_vld[LAT-1]) begin
      bus.rsp_valid[tag_id[LAT-1]] = 1'b1;
      bus.rsp_data = add_out;
    end
  end

`ifdef ADD_ARB_COUT_EN
  // Carry out of the MSB column, recovered from the operand MSBs and the sum MSB.
  always_comb begin
    bus.rsp_cout = 1'b0;
    if (tag_vld[LAT-1])
      bus.rsp_cout = (tag_a[LAT-1] & tag_b[LAT-1]) |
                     ((tag_a[LAT-1] | tag_b[LAT-1]) & ~add_out[WIDTH-1]);
  end
`endif
endmodule
